// File: rtl/pwm_shadow_update_ctrl.sv
// Shadow-register update sequencer for one PWM carrier: arms on a bus commit,
// waits for a (decimated) carrier event, then emits a single maskevent pulse.
module pwm_shadow_update_ctrl #(
   parameter int DIV_WIDTH = 4,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pwm_onoff,
   input  logic                 carr_zero,
   input  logic                 carr_peak,
   input  logic [1:0]           cfg_mode,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   input  logic                 commit,
   output logic                 maskevent,
   output logic                 update_pending,
   output logic                 commit_ack,
   output logic [CNT_WIDTH-1:0] update_cnt,
   output logic [CNT_WIDTH-1:0] merge_cnt
);

   localparam logic PWM_ON = 1'b1;

   typedef enum logic [1:0] {IDLE, ARMED, FIRE} state_t;

   state_t               state_q;
   logic [DIV_WIDTH-1:0] ev_cnt_q, ev_cnt_d;
   logic                 maskevent_q, update_pending_q, commit_ack_q;
   logic [CNT_WIDTH-1:0] update_cnt_q, merge_cnt_q;
   logic                 pwm_on, qev, tick, immediate;

   assign pwm_on    = (pwm_onoff == PWM_ON);
   assign immediate = (cfg_mode == 2'd3);

   // Coincident zero and peak in mode 2 collapse into a single event.
   always_comb begin
      qev = 1'b0;
      case (cfg_mode)
         2'd0:    qev = carr_zero;
         2'd1:    qev = carr_peak;
         2'd2:    qev = carr_zero | carr_peak;
         default: qev = 1'b0;
      endcase
   end

   // >= rather than == so a cfg_div lowered below the running count still ticks.
   assign tick = pwm_on && qev && (ev_cnt_q >= cfg_div);

   // The divider free-runs independently of pending updates to keep phase lock.
   always_comb begin
      ev_cnt_d = ev_cnt_q;
      if (!pwm_on || tick) ev_cnt_d = '0;
      else if (qev)        ev_cnt_d = ev_cnt_q + DIV_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) ev_cnt_q <= '0;
      else       ev_cnt_q <= ev_cnt_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= IDLE;
         maskevent_q      <= 1'b0;
         update_pending_q <= 1'b0;
         commit_ack_q     <= 1'b0;
         update_cnt_q     <= '0;
         merge_cnt_q      <= '0;
      end else begin
         maskevent_q  <= 1'b0;
         commit_ack_q <= 1'b0;
         if (!pwm_on) begin
            // Shadows are transparent while off: acknowledge directly, never pulse.
            state_q          <= IDLE;
            update_pending_q <= 1'b0;
            commit_ack_q     <= commit;
         end else begin
            case (state_q)
               IDLE: begin
                  if (commit) begin
                     state_q          <= ARMED;
                     update_pending_q <= 1'b1;
                  end
               end
               ARMED: begin
                  if (commit && merge_cnt_q != '1)
                     merge_cnt_q <= merge_cnt_q + CNT_WIDTH'(1);
                  if (tick || immediate) begin
                     state_q          <= FIRE;
                     maskevent_q      <= 1'b1;
                     commit_ack_q     <= 1'b1;
                     update_pending_q <= 1'b0;
                     update_cnt_q     <= update_cnt_q + CNT_WIDTH'(1);
                  end
               end
               FIRE: begin
                  state_q          <= commit ? ARMED : IDLE;
                  update_pending_q <= commit;
               end
               default: begin
                  state_q          <= IDLE;
                  update_pending_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign maskevent      = maskevent_q;
   assign update_pending = update_pending_q;
   assign commit_ack     = commit_ack_q;
   assign update_cnt     = update_cnt_q;
   assign merge_cnt      = merge_cnt_q;

endmodule

// File: doc/pwm_shadow_update_ctrl.md
Name: pwm_shadow_update_ctrl

Overview:
Sequences shadow-register updates for one PWM carrier channel. The bus side signals that new compare/period values are written (commit). The block waits for a qualifying carrier event (zero, peak, both, or immediate), optionally decimated by a divider. It then issues a single-cycle maskevent that drives the channel's 16-bit shadow registers. It sits between the AXI register bank and the per-carrier shadow registers, one instance per carrier.

Parameters:
DIV_WIDTH, 4, width of update decimation divider (update every cfg_div+1 qualifying events)
CNT_WIDTH, 8, width of update_cnt and merge_cnt status counters

Ports:
clk  in  1  system clock
reset  in  1  reset, synchronous, active-high
pwm_onoff  in  1  _pwm_onoff (PKG_pwm); PWM_ON/PWM_OFF for this carrier
carr_zero  in  1  one-cycle pulse, carrier counter at 0
carr_peak  in  1  one-cycle pulse, carrier counter at period (top)
cfg_mode  in  2  0=zero, 1=peak, 2=zero or peak, 3=immediate
cfg_div  in  DIV_WIDTH  decimation value N; update on every (N+1)th qualifying event
commit  in  1  one-cycle pulse, new shadow values written by bus
maskevent  out  1  one-cycle pulse to shadow registers
update_pending  out  1  high while a committed update awaits its event
commit_ack  out  1  one-cycle pulse, commit applied (with maskevent, or pwm off)
update_cnt  out  CNT_WIDTH  number of maskevent pulses, wraps
merge_cnt  out  CNT_WIDTH  commits merged into an already-pending update, saturates

Behaviour:
- Reset: state IDLE, ev_cnt=0, maskevent=0, update_pending=0, commit_ack=0, update_cnt=0, merge_cnt=0. Reset mid-operation discards any pending update and emits no pulse.
- Qualifying event qev: mode0 carr_zero; mode1 carr_peak; mode2 carr_zero|carr_peak; simultaneous zero and peak count as one event; mode3 not event-driven.
- Divider: ev_cnt (DIV_WIDTH) increments on each qev while PWM_ON. tick = qev && ev_cnt>=cfg_div. On tick ev_cnt<=0. The >= handles cfg_div lowered below ev_cnt. ev_cnt runs whether or not an update is pending, so update phase stays locked to the carrier.
- FSM states: IDLE, ARMED, FIRE.
  - IDLE: commit && PWM_ON -> ARMED. A tick in the same cycle as the commit does not fire; the update waits for the next tick.
  - ARMED: update_pending=1. Fires (-> FIRE) on tick, or on the first ARMED cycle when cfg_mode=3. A commit while ARMED increments merge_cnt (saturating), stays ARMED, adds no extra pulse. A commit coincident with a tick still fires on that tick.
  - FIRE: maskevent=1 and commit_ack=1 for exactly one cycle, update_cnt++ (wraps). Next state IDLE, or ARMED if a commit arrives in the FIRE cycle.
- Latency: tick in ARMED at cycle n -> maskevent at n+1. Mode3: commit at n -> ARMED n+1 -> maskevent n+2.
- pwm_onoff=PWM_OFF: shadow registers are transparent, so no maskevent is generated. ev_cnt held at 0. Any state -> IDLE. A commit while off gives commit_ack next cycle, update_cnt unchanged, no pending.
- PWM_OFF->PWM_ON with nothing pending: stays IDLE, ev_cnt starts from 0.
- cfg_mode/cfg_div are used live; a change while ARMED applies from the next cycle.
- All outputs registered.

Test Plan:
1. reset, PWM_ON, mode0, div0; commit at c10; carr_zero at c20 -> maskevent and commit_ack at c21 only; update_pending high c11..c20; update_cnt=1.
2. mode2, div2; commit, then zero, peak, zero, peak pulses -> maskevent one cycle after the third qualifying event (count includes events before commit per ev_cnt phase); ev_cnt back to 0.
3. mode1; commit, 3 further commits before carr_peak -> single maskevent, merge_cnt=3, update_cnt=1; 300 merges saturate merge_cnt at 255.
4. mode3; commit at c5 -> maskevent at c7, no carrier pulses needed; commit during FIRE cycle -> second maskevent 2 cycles later.
5. ARMED, then PWM_OFF -> update_pending drops next cycle, no maskevent; commit while off -> commit_ack next cycle, update_cnt unchanged.
6. ARMED; reset asserted on the same cycle as a tick -> no maskevent, all outputs 0; commit coincident with carr_zero in IDLE (mode0) -> fires on the following carr_zero, not the current one.
